// File: rtl/mem_wb_stage.sv
// Write-back stage: in-order result buffer between MEM and the register-file write port,
// with a forwarding lookup over results that are still waiting to be written back.
module mem_wb_stage #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_write_back,
    input  logic               in_mem_to_reg,
    input  logic [DATA_W-1:0]  in_memory_data,
    input  logic [DATA_W-1:0]  in_alu_res,
    input  logic [31:0]        in_des,

    input  logic               flush,
    input  logic               wb_stall,

    output logic               rf_we,
    output logic [ADDR_W-1:0]  rf_waddr,
    output logic [DATA_W-1:0]  rf_wdata,

    input  logic [ADDR_W-1:0]  fwd_raddr,
    output logic               fwd_hit,
    output logic [DATA_W-1:0]  fwd_data,

    output logic [COUNT_W-1:0] retired_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  we_q;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [COUNT_W-1:0] retired_q;

    logic               not_empty;
    logic               accept, retire;
    logic               new_we;
    logic [ADDR_W-1:0]  new_addr;
    logic [DATA_W-1:0]  new_data;
    logic [PTR_W-1:0]   fwd_idx;

    // Only the low ADDR_W bits of the destination field name a register.
    logic unused_des_hi;
    assign unused_des_hi = ^in_des[31:ADDR_W];

    assign not_empty = (count_q != '0);
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign accept    = in_valid && in_ready && !flush;
    assign retire    = not_empty && !wb_stall && !flush;

    // Write-back source is resolved at capture so the buffer holds final values.
    assign new_addr = in_des[ADDR_W-1:0];
    assign new_we   = in_write_back && (new_addr != '0);
    assign new_data = in_mem_to_reg ? in_memory_data : in_alu_res;

    assign rf_waddr    = not_empty ? addr_q[rd_ptr_q] : '0;
    assign rf_wdata    = not_empty ? data_q[rd_ptr_q] : '0;
    assign rf_we       = not_empty && we_q[rd_ptr_q] && !wb_stall && !flush;
    assign retired_cnt = retired_q;

    always_comb begin
        count_d = count_q;
        unique case ({accept, retire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            we_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else if (flush) begin
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (retire) begin
                valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q          <= rd_ptr_q + PTR_W'(1);
            end
            // Accept only happens when not full, so it never targets the slot being retired.
            if (accept) begin
                valid_q[wr_ptr_q] <= 1'b1;
                we_q[wr_ptr_q]    <= new_we;
                addr_q[wr_ptr_q]  <= new_addr;
                data_q[wr_ptr_q]  <= new_data;
                wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
        end else if (rf_we) begin
            retired_q <= retired_q + COUNT_W'(1);
        end
    end

    // Walk oldest to youngest so the last match (youngest) wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr_q + PTR_W'(i);
            if (valid_q[fwd_idx] && we_q[fwd_idx] && (fwd_raddr != '0) &&
                (addr_q[fwd_idx] == fwd_raddr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[fwd_idx];
            end
        end
    end

endmodule
